// File: rtl/serial_cfg_master.sv
// Serialises a parallel config word MSB-first on a divided strobe (o_sclk) and data line (o_sdin).
// Accepts the word over valid/ready and reports completion with a one-cycle o_done pulse.
module serial_cfg_master #(
  parameter int DATA_W  = 5,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_abort,
  output logic              o_sclk,
  output logic              o_sdin,
  output logic              o_busy,
  output logic              o_done
);

  localparam int PH_W = $clog2(CLK_DIV + 1);
  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_INIT = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, BIT_LO, BIT_HI, DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BC_W-1:0]     bitcnt_q, bitcnt_d;
  logic [PH_W-1:0]     phcnt_q, phcnt_d;
  logic                ready_q, ready_d;
  logic                sclk_q, sclk_d;
  logic                sdin_q, sdin_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // NOTE: every signal gets a default before the case, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    phcnt_d  = phcnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_valid && !i_abort) begin
          shreg_d  = i_data;
          bitcnt_d = BC_INIT;
          phcnt_d  = '0;
          state_d  = BIT_LO;
        end
      end
      BIT_LO: begin
        if (phcnt_q == PH_LAST) begin
          phcnt_d = '0;
          state_d = BIT_HI;
        end else begin
          phcnt_d = phcnt_q + PH_W'(1);
        end
      end
      BIT_HI: begin
        if (phcnt_q == PH_LAST) begin
          phcnt_d = '0;
          if (bitcnt_q != '0) begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - BC_W'(1);
            state_d  = BIT_LO;
          end else begin
            state_d = DONE;
          end
        end else begin
          phcnt_d = phcnt_q + PH_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides any in-frame progress; in IDLE it only suppresses the accept above.
    if (i_abort && state_q != IDLE) begin
      state_d = IDLE;
      phcnt_d = '0;
    end

    // Outputs are registered versions of what the next state implies.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    sclk_d  = (state_d == BIT_HI);
    done_d  = (state_d == DONE);
    sdin_d  = (state_d == BIT_LO || state_d == BIT_HI) ? shreg_d[DATA_W-1] : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      phcnt_q  <= '0;
      ready_q  <= 1'b1;
      sclk_q   <= 1'b0;
      sdin_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      phcnt_q  <= phcnt_d;
      ready_q  <= ready_d;
      sclk_q   <= sclk_d;
      sdin_q   <= sdin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_ready = ready_q;
  assign o_sclk  = sclk_q;
  assign o_sdin  = sdin_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_serial_cfg_master.sv
// Directed bench for serial_cfg_master: default instance (DATA_W=5, CLK_DIV=2)
// plus a minimal instance (DATA_W=1, CLK_DIV=1).
module tb_serial_cfg_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] i_data;
  logic       i_valid, i_abort;
  logic       o_ready, o_sclk, o_sdin, o_busy, o_done;
  logic [0:0] b_data;
  logic       b_valid, b_abort;
  logic       b_ready, b_sclk, b_sdin, b_busy, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_cfg_master #(.DATA_W(5), .CLK_DIV(2)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_abort(i_abort), .o_sclk(o_sclk), .o_sdin(o_sdin), .o_busy(o_busy), .o_done(o_done)
  );

  serial_cfg_master #(.DATA_W(1), .CLK_DIV(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
    .i_abort(b_abort), .o_sclk(b_sclk), .o_sdin(b_sdin), .o_busy(b_busy), .o_done(b_done)
  );

  typedef struct {
    logic [4:0] data;
    logic [4:0] exp_bits;  // bits in the order they appear at the o_sclk rises, first in bit 4
    bit         garble;    // scramble i_data/i_valid while the frame is in progress
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [4:0] d);
    @(negedge clk);
    i_data  = d;
    i_valid = 1'b1;
    i_abort = 1'b0;
    @(posedge clk);
  endtask

  // Called right after the accepting edge; follows the frame to its end plus one cycle.
  task automatic monitor_frame(input string tag, input logic [4:0] exp_bits, input bit garble,
                               input bit keep_valid, input logic [4:0] next_data);
    logic [4:0] cap = '0;
    int nrise = 0;
    int done_cyc = -1;
    logic prev_sclk = 1'b0;
    logic prev_sdin = 1'b0;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, " busy c1"}, o_busy, 1'b1);
        check({tag, " ready c1"}, o_ready, 1'b0);
      end
      if (!keep_valid && !garble && c == 1) i_valid = 1'b0;
      if (garble && !o_done) check({tag, " ready while busy"}, o_ready, 1'b0);
      if (o_sclk && !prev_sclk) begin
        check({tag, " rise cycle"}, c, 3 + 4 * nrise);
        cap = {cap[3:0], o_sdin};
        nrise++;
      end
      if (o_sclk && prev_sclk) check({tag, " sdin stable hi"}, o_sdin, prev_sdin);
      if (o_done) begin
        done_cyc = c;
        check({tag, " sclk at done"}, o_sclk, 1'b0);
        check({tag, " sdin at done"}, o_sdin, 1'b0);
        if (keep_valid) i_data = next_data;
      end
      if (garble) begin
        i_valid = (c < 18) ? 1'($urandom) : 1'b0;
        i_data  = 5'($urandom);
      end
      prev_sclk = o_sclk;
      prev_sdin = o_sdin;
    end
    check({tag, " done cycle"}, done_cyc, 21);
    check({tag, " rise count"}, nrise, 5);
    check({tag, " bits"}, cap, exp_bits);
    @(negedge clk);
    check({tag, " done one cycle"}, o_done, 1'b0);
    check({tag, " ready after"}, o_ready, 1'b1);
  endtask

  vec_t vecs[4];
  bit   saw_done;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{data: 5'b10110, exp_bits: 5'b10110, garble: 1'b0};
    vecs[1] = '{data: 5'b01001, exp_bits: 5'b01001, garble: 1'b0};
    vecs[2] = '{data: 5'b00000, exp_bits: 5'b00000, garble: 1'b1};
    vecs[3] = '{data: 5'b11010, exp_bits: 5'b11010, garble: 1'b1};

    rst = 1'b1; i_data = '0; i_valid = 1'b0; i_abort = 1'b0;
    b_data = '0; b_valid = 1'b0; b_abort = 1'b0;
    #1;
    check("reset ready", o_ready, 1'b1);
    check("reset sclk", o_sclk, 1'b0);
    check("reset sdin", o_sdin, 1'b0);
    check("reset busy", o_busy, 1'b0);
    check("reset done", o_done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven frames, including scrambled inputs while busy.
    for (int i = 0; i < 4; i++) begin
      accept(vecs[i].data);
      monitor_frame($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].garble, 1'b0, 5'b0);
    end

    // i_valid held across two frames: second accept on the first IDLE cycle.
    accept(5'b11111);
    monitor_frame("b2b f1", 5'b11111, 1'b0, 1'b1, 5'b00001);
    @(posedge clk);
    monitor_frame("b2b f2", 5'b00001, 1'b0, 1'b0, 5'b0);

    // Abort sampled at edge 9 -> IDLE in cycle 10, no done pulse.
    accept(5'b10110);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) i_valid = 1'b0;
      if (c == 9) i_abort = 1'b1;
    end
    @(negedge clk);
    i_abort = 1'b0;
    check("abort sclk", o_sclk, 1'b0);
    check("abort sdin", o_sdin, 1'b0);
    check("abort ready", o_ready, 1'b1);
    check("abort busy", o_busy, 1'b0);
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    check("abort no done", saw_done, 1'b0);
    accept(5'b01101);
    monitor_frame("post abort", 5'b01101, 1'b0, 1'b0, 5'b0);

    // Abort in IDLE blocks the accept.
    @(negedge clk);
    i_data = 5'b10101; i_valid = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_abort = 1'b0;
    check("idle abort ready", o_ready, 1'b1);
    check("idle abort busy", o_busy, 1'b0);

    // Asynchronous reset mid-frame, while o_sclk/o_sdin are high.
    accept(5'b10110);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) i_valid = 1'b0;
    end
    check("pre-reset sclk", o_sclk, 1'b1);
    rst = 1'b1;
    #1;
    check("async rst sclk", o_sclk, 1'b0);
    check("async rst sdin", o_sdin, 1'b0);
    check("async rst ready", o_ready, 1'b1);
    check("async rst busy", o_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    check("rst no done", saw_done, 1'b0);

    // Minimal instance: DATA_W=1, CLK_DIV=1.
    @(negedge clk);
    b_data = 1'b1; b_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    check("w1 c1 sclk", b_sclk, 1'b0);
    check("w1 c1 sdin", b_sdin, 1'b1);
    check("w1 c1 ready", b_ready, 1'b0);
    @(negedge clk);
    check("w1 c2 sclk", b_sclk, 1'b1);
    check("w1 c2 sdin", b_sdin, 1'b1);
    check("w1 c2 done", b_done, 1'b0);
    @(negedge clk);
    check("w1 c3 done", b_done, 1'b1);
    check("w1 c3 sclk", b_sclk, 1'b0);
    check("w1 c3 busy", b_busy, 1'b1);
    @(negedge clk);
    check("w1 c4 done", b_done, 1'b0);
    check("w1 c4 ready", b_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
